gate_exerciser: RTL

- Self-checking stimulus/response engine for the team's two-input gate library.
- Drives a shared a/b input pair into seven gate instances (And, Or, Nor, Nand, Xor, Xnor, Not) and walks all four input vectors.
- Samples the seven gate outputs after a settle delay, compares them against an internal golden model, and reports a per-gate error mask plus pass/done status.
- Used as the on-chip or bench-level checker for gate-level netlists.

---
 rtl/gate_pkg.sv | 25 ++
 rtl/gate_golden.sv | 47 ++++
 rtl/gate_exerciser.sv | 101 ++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared types and constants for the gate exerciser.
// Holds the FSM state enum, y_in/err_mask bit positions and sweep sizes.
package gate_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_GATES = 7;
    localparam int NUM_VEC   = 4;

    localparam int IDX_AND  = 0;
    localparam int IDX_OR   = 1;
    localparam int IDX_NOR  = 2;
    localparam int IDX_NAND = 3;
    localparam int IDX_XOR  = 4;
    localparam int IDX_XNOR = 5;
    localparam int IDX_NOT  = 6;

    localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

endpackage

// File: rtl/gate_golden.sv
// Golden expected outputs for the two-input gate library.
// Ports: a, b in; expected[6:0] out, indexed by the gate_pkg IDX_* constants.
module and2 (input logic a, input logic b, output logic y);
    assign y = a & b;
endmodule

module or2 (input logic a, input logic b, output logic y);
    assign y = a | b;
endmodule

module nor2 (input logic a, input logic b, output logic y);
    assign y = ~(a | b);
endmodule

module nand2 (input logic a, input logic b, output logic y);
    assign y = ~(a & b);
endmodule

module xor2 (input logic a, input logic b, output logic y);
    assign y = a ^ b;
endmodule

module xnor2 (input logic a, input logic b, output logic y);
    assign y = ~(a ^ b);
endmodule

module inv1 (input logic a, output logic y);
    assign y = ~a;
endmodule

module gate_golden
    import gate_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] expected
);

    and2  u_and  (.a(a), .b(b), .y(expected[IDX_AND]));
    or2   u_or   (.a(a), .b(b), .y(expected[IDX_OR]));
    nor2  u_nor  (.a(a), .b(b), .y(expected[IDX_NOR]));
    nand2 u_nand (.a(a), .b(b), .y(expected[IDX_NAND]));
    xor2  u_xor  (.a(a), .b(b), .y(expected[IDX_XOR]));
    xnor2 u_xnor (.a(a), .b(b), .y(expected[IDX_XNOR]));
    inv1  u_not  (.a(a), .y(expected[IDX_NOT]));

endmodule

// File: rtl/gate_exerciser.sv
// Sweeps a/b through 00,01,10,11, samples the seven gate outputs after a
// settle delay and compares them against gate_golden.
// Ports: clk, rst (async, active-high), start, y_in[6:0] in;
//        a_out, b_out, busy, done, pass, err_mask[6:0], err_count[2:0] out.
module gate_exerciser
    import gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_mask,
    output logic [2:0] err_count
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] vec;
    logic [7:0] cnt;
    logic [6:0] expected;
    logic [6:0] diff;
    logic [6:0] mask_next;

    // Stimulus comes straight from the vector register; vec is kept at 0
    // outside a sweep so a/b read 00 while idle.
    assign a_out = vec[1];
    assign b_out = vec[0];

    gate_golden u_golden (
        .a        (a_out),
        .b        (b_out),
        .expected (expected)
    );

    assign diff      = y_in ^ expected;
    assign mask_next = err_mask | diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= 2'd0;
            cnt       <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_mask  <= 7'd0;
            err_count <= 3'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    vec  <= 2'd0;
                    busy <= 1'b0;
                    if (start) begin
                        err_mask  <= 7'd0;
                        err_count <= 3'd0;
                        pass      <= 1'b0;
                        cnt       <= 8'd0;
                        busy      <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == SETTLE_LAST)
                        state <= CHECK;
                end
                CHECK: begin
                    err_mask <= mask_next;
                    if (|diff)
                        err_count <= err_count + 3'd1;
                    if (vec == LAST_VEC) begin
                        // pass must already be valid while done is high
                        done  <= 1'b1;
                        pass  <= (mask_next == 7'd0);
                        state <= DONE;
                    end else begin
                        vec   <= vec + 2'd1;
                        cnt   <= 8'd0;
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    vec   <= 2'd0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
